// File: rtl/iiitb_vm_change_dispenser.sv
// Coin-return back end: queues change requests, picks coins from the 5/10 hoppers,
// confirms each coin on the exit sensor with a timeout, and tracks inventory.
//
//   state  | meaning
//   IDLE   | waiting for a queued request
//   SELECT | choose next coin from remaining amount and stock
//   EJ5    | eject5 pulse
//   EJ10   | eject10 pulse
//   WAIT   | waiting for coin_seen, timer running
//   FAULT  | out of stock or coin not seen; wait for fault_clr
module iiitb_vm_change_dispenser #(
  parameter int INV_W   = 8,
  parameter int TIMEOUT = 15,
  parameter int QDEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       change_req,
  input  logic             coin_seen,
  input  logic             refill5,
  input  logic             refill10,
  input  logic             fault_clr,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             fault,
  output logic             drop,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv10
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJ5, S_EJ10, S_WAIT, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       fifo_q [QDEPTH];
  logic [1:0]       fifo_d [QDEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       rem_q, rem_d;
  logic             coin10_q, coin10_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [INV_W-1:0] inv5_q, inv5_d, inv10_q, inv10_d;
  logic             eject5_q, eject5_d, eject10_q, eject10_d;
  logic             busy_q, busy_d, fault_q, fault_d, drop_q, drop_d;

  logic push, full, accept, pop, dec5, dec10;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] v,
                                                input logic inc, input logic dec);
    logic [INV_W-1:0] r;
    r = v;
    if (inc && !dec && v != '1)  r = v + INV_W'(1);
    else if (dec && !inc)        r = v - INV_W'(1);
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    coin10_d = coin10_q;
    timer_d  = timer_q;
    pop      = 1'b0;
    dec5     = 1'b0;
    dec10    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          rem_d   = fifo_q[rd_ptr_q];
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 2'd2) begin
          if (inv10_q != '0)              state_d = S_EJ10;
          else if (inv5_q >= INV_W'(2))   state_d = S_EJ5;
          else                            state_d = S_FAULT;
        end else begin
          if (inv5_q != '0)               state_d = S_EJ5;
          else                            state_d = S_FAULT;
        end
      end
      S_EJ5: begin
        coin10_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_EJ10: begin
        coin10_d = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (coin_seen) begin
          dec10 = coin10_q;
          dec5  = !coin10_q;
          rem_d = rem_q - (coin10_q ? 2'd2 : 2'd1);
          if (rem_d == 2'd0) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SELECT;
          end
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TW'(TIMEOUT)) state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // the 2-bit code equals the amount in 5-unit multiples
    push     = (change_req == 2'b01) || (change_req == 2'b10);
    full     = (count_q == CW'(QDEPTH));
    accept   = push && (!full || pop);
    drop_d   = push && full && !pop;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = change_req;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (pop && !accept) count_d = count_q - CW'(1);

    inv5_d  = inv_next(inv5_q, refill5, dec5);
    inv10_d = inv_next(inv10_q, refill10, dec10);

    eject5_d  = (state_d == S_EJ5);
    eject10_d = (state_d == S_EJ10);
    fault_d   = (state_d == S_FAULT);
    busy_d    = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      coin10_q  <= 1'b0;
      timer_q   <= '0;
      inv5_q    <= '0;
      inv10_q   <= '0;
      eject5_q  <= 1'b0;
      eject10_q <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      coin10_q  <= coin10_d;
      timer_q   <= timer_d;
      inv5_q    <= inv5_d;
      inv10_q   <= inv10_d;
      eject5_q  <= eject5_d;
      eject10_q <= eject10_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      drop_q    <= drop_d;
    end
  end

  assign eject5  = eject5_q;
  assign eject10 = eject10_q;
  assign busy    = busy_q;
  assign fault   = fault_q;
  assign drop    = drop_q;
  assign inv5    = inv5_q;
  assign inv10   = inv10_q;

endmodule

// File: tb/tb_iiitb_vm_change_dispenser.sv
// Directed bench for the change dispenser; expected coins are queued when a
// request is driven and checked by a monitor when an eject pulse appears.
module tb_iiitb_vm_change_dispenser;

  logic       clock;
  logic       reset;
  logic [1:0] change_req;
  logic       coin_seen, refill5, refill10, fault_clr;
  logic       eject5, eject10, busy, fault, drop;
  logic [7:0] inv5, inv10;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int exp_q [$];

  iiitb_vm_change_dispenser #(.INV_W(8), .TIMEOUT(15), .QDEPTH(4)) dut (
    .clock(clock), .reset(reset), .change_req(change_req), .coin_seen(coin_seen),
    .refill5(refill5), .refill10(refill10), .fault_clr(fault_clr),
    .eject5(eject5), .eject10(eject10), .busy(busy), .fault(fault), .drop(drop),
    .inv5(inv5), .inv10(inv10)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // scoreboard: each eject pulse must match the next expected coin value
  always @(negedge clock) begin
    if (eject5 || eject10) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_eject: observed eject5=%0b eject10=%0b expected none",
               eject5, eject10);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        chk("eject_coin", {30'd0, eject10, eject5}, (e == 10) ? 32'd2 : 32'd1);
      end
    end
  end

  task automatic wait_eject(input string tag, output int cycles);
    cycles = 0;
    while (!(eject5 || eject10) && cycles < 10) begin
      tick();
      cycles++;
    end
    chk({tag, "_eject_seen"}, {31'd0, eject5 | eject10}, 32'd1);
  endtask

  task automatic ack_coin(input string tag, input logic with_refill5, output int cycles);
    wait_eject(tag, cycles);
    tick();
    chk({tag, "_eject_width"}, {31'd0, eject5 | eject10}, 32'd0);
    coin_seen = 1'b1;
    refill5   = with_refill5;
    tick();
    coin_seen = 1'b0;
    refill5   = 1'b0;
  endtask

  task automatic request(input logic [1:0] code);
    change_req = code;
    tick();
    change_req = 2'b00;
  endtask

  initial begin
    reset = 1'b0; change_req = 2'b00; coin_seen = 1'b0;
    refill5 = 1'b0; refill10 = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    chk("rst_eject", {30'd0, eject10, eject5}, 32'd0);
    chk("rst_busy_fault_drop", {29'd0, busy, fault, drop}, 32'd0);
    chk("rst_inv", {16'd0, inv10, inv5}, 32'd0);
    reset = 1'b1;
    tick();

    // single 5-unit payout
    refill5 = 1'b1; repeat (3) tick(); refill5 = 1'b0;
    chk("refill_inv5", inv5, 3);
    exp_q.push_back(5);
    request(2'b01);
    chk("t1_busy_after_push", busy, 1);
    ack_coin("t1", 1'b0, lat);
    chk("t1_eject_latency", lat, 2);
    chk("t1_inv5", inv5, 2);
    chk("t1_busy", busy, 0);
    chk("t1_fault", fault, 0);

    // 10 units with no 10-coins: two 5-coins
    refill5 = 1'b1; tick(); refill5 = 1'b0;
    exp_q.push_back(5); exp_q.push_back(5);
    request(2'b10);
    ack_coin("t2a", 1'b0, lat);
    ack_coin("t2b", 1'b0, lat);
    chk("t2_inv5", inv5, 1);
    chk("t2_inv10", inv10, 0);
    chk("t2_busy", busy, 0);

    // insufficient stock: FAULT straight from SELECT
    request(2'b10);
    tick();
    chk("t3_fault_early", fault, 0);
    tick();
    chk("t3_fault", fault, 1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("t3_fault_cleared", fault, 0);
    chk("t3_busy", busy, 0);

    // timeout: 15 WAIT cycles without coin_seen
    refill10 = 1'b1; tick(); refill10 = 1'b0;
    exp_q.push_back(10);
    request(2'b10);
    wait_eject("t4", lat);
    repeat (15) tick();
    chk("t4_fault_before_timeout", fault, 0);
    tick();
    chk("t4_fault_at_timeout", fault, 1);
    chk("t4_inv10", inv10, 1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("t4_busy", busy, 0);

    // overflow with empty hoppers
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      change_req = 2'b01;
      tick();
      chk($sformatf("t5_drop_%0d", i), drop, (i == 4) ? 1 : 0);
    end
    change_req = 2'b00;
    tick();
    chk("t5_drop_one_cycle", drop, 0);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = 0;
      while (!fault && k < 6) begin tick(); k++; end
      chk($sformatf("t5_fault_%0d", i), fault, 1);
      fault_clr = 1'b1; tick(); fault_clr = 1'b0;
      chk($sformatf("t5_busy_after_clr_%0d", i), busy, (i < 3) ? 1 : 0);
    end
    tick();
    chk("t5_idle_fault", fault, 0);

    // refill5 coincident with a 5-coin acknowledge
    refill5 = 1'b1; repeat (2) tick(); refill5 = 1'b0;
    exp_q.push_back(5);
    request(2'b01);
    ack_coin("t6", 1'b1, lat);
    chk("t6_inv5_unchanged", inv5, 2);
    chk("t6_busy", busy, 0);

    // refill10 saturation
    refill10 = 1'b1;
    repeat (255) tick();
    chk("t6_inv10_max", inv10, 255);
    tick();
    chk("t6_inv10_sat", inv10, 255);
    refill10 = 1'b0;

    // reset during WAIT with two requests queued
    change_req = 2'b01; tick(); tick(); change_req = 2'b00;
    exp_q.push_back(5);
    wait_eject("t7", lat);
    tick();
    reset = 1'b0; tick();
    chk("t7_busy", busy, 0);
    chk("t7_inv", {16'd0, inv10, inv5}, 0);
    chk("t7_outs", {28'd0, eject10, eject5, fault, drop}, 0);
    reset = 1'b1;
    coin_seen = 1'b1; tick(); coin_seen = 1'b0;
    repeat (6) tick();
    chk("t7_busy_after", busy, 0);
    chk("t7_inv5_after", inv5, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
